// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: in-order branch queue matching fetch predictions against execute outcomes
module branch_resolve_ctrl #(
    parameter int DEPTH = 4,
    parameter int PCW   = 32,
    parameter int CNTW  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_br_valid,
    input  logic                     fetch_pred_taken,
    input  logic [PCW-1:0]           fetch_alt_pc,
    output logic                     fetch_ready,
    input  logic                     ex_res_valid,
    input  logic                     ex_actual_taken,
    output logic [2:0]               pred_result,
    output logic                     flush,
    output logic [PCW-1:0]           redirect_pc,
    input  logic                     cfg_mode_wr,
    input  logic [1:0]               cfg_mode,
    output logic [1:0]               forcer,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [CNTW-1:0]          hit_count,
    output logic [CNTW-1:0]          miss_count,
    output logic                     err_underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [PCW:0]    mem_q [DEPTH];
    logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
    logic [2:0]      pres_q, pres_d;
    logic            flush_q, flush_d;
    logic [PCW-1:0]  redir_q, redir_d;
    logic [CNTW-1:0] hit_q, hit_d, miss_q, miss_d;
    logic            err_q, err_d;
    logic            pend_v_q, pend_v_d;
    logic [1:0]      pend_q, pend_d, forcer_q, forcer_d;
    logic            full, empty, push, res, hit, miss, idle;
    logic [PCW:0]    head;

    // Pointer, result, statistics and mode next-state; a miss empties the queue and drops any same-cycle push
    always_comb begin
        full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty    = wr_q == rd_q;
        push     = fetch_br_valid && !full;
        res      = ex_res_valid && !empty;
        head     = mem_q[rd_q[AW-1:0]];
        hit      = res && (head[PCW] == ex_actual_taken);
        miss     = res && !hit;
        idle     = empty && !fetch_br_valid && !ex_res_valid;
        rd_d     = rd_q + (AW+1)'(res);
        wr_d     = miss ? rd_d : wr_q + (AW+1)'(push);
        pres_d   = {res, res & head[PCW], res & ex_actual_taken};
        flush_d  = miss;
        redir_d  = miss ? head[PCW-1:0] : '0;
        hit_d    = hit_q + CNTW'(hit && !(&hit_q));
        miss_d   = miss_q + CNTW'(miss && !(&miss_q));
        err_d    = err_q | (ex_res_valid && empty);
        pend_v_d = cfg_mode_wr ? 1'b1 : (pend_v_q && !idle);
        pend_d   = cfg_mode_wr ? cfg_mode : pend_q;
        forcer_d = (!cfg_mode_wr && pend_v_q && idle) ? pend_q : forcer_q;
    end

    // Control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            pres_q   <= '0;
            flush_q  <= 1'b0;
            redir_q  <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            err_q    <= 1'b0;
            pend_v_q <= 1'b0;
            pend_q   <= 2'b01;
            forcer_q <= 2'b01;
        end else begin
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            pres_q   <= pres_d;
            flush_q  <= flush_d;
            redir_q  <= redir_d;
            hit_q    <= hit_d;
            miss_q   <= miss_d;
            err_q    <= err_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            forcer_q <= forcer_d;
        end
    end

    // Queue storage; contents are only meaningful between the pointers so it needs no reset
    always_ff @(posedge clk) begin
        if (push && !miss) mem_q[wr_q[AW-1:0]] <= {fetch_pred_taken, fetch_alt_pc};
    end

    assign fetch_ready   = !full;
    assign occupancy     = wr_q - rd_q;
    assign pred_result   = pres_q;
    assign flush         = flush_q;
    assign redirect_pc   = redir_q;
    assign forcer        = forcer_q;
    assign hit_count     = hit_q;
    assign miss_count    = miss_q;
    assign err_underflow = err_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed checks of queueing, resolve, flush, mode and counter behaviour
module tb_branch_resolve_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_br_valid = 1'b0, fetch_pred_taken = 1'b0;
    logic [31:0] fetch_alt_pc = '0;
    logic        fetch_ready;
    logic        ex_res_valid = 1'b0, ex_actual_taken = 1'b0;
    logic [2:0]  pred_result;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        cfg_mode_wr = 1'b0;
    logic [1:0]  cfg_mode = 2'b00;
    logic [1:0]  forcer;
    logic [2:0]  occupancy;
    logic [3:0]  hit_count, miss_count;
    logic        err_underflow;
    int          checks = 0, errors = 0;
    logic        mpred[$];
    logic [31:0] malt[$];
    logic        a;

    branch_resolve_ctrl #(.DEPTH(4), .PCW(32), .CNTW(4)) dut (
        .clk(clk), .rst(rst),
        .fetch_br_valid(fetch_br_valid), .fetch_pred_taken(fetch_pred_taken),
        .fetch_alt_pc(fetch_alt_pc), .fetch_ready(fetch_ready),
        .ex_res_valid(ex_res_valid), .ex_actual_taken(ex_actual_taken),
        .pred_result(pred_result), .flush(flush), .redirect_pc(redirect_pc),
        .cfg_mode_wr(cfg_mode_wr), .cfg_mode(cfg_mode), .forcer(forcer),
        .occupancy(occupancy), .hit_count(hit_count), .miss_count(miss_count),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic fv, input logic fp, input logic [31:0] alt, input logic rv, input logic act);
        fetch_br_valid = fv; fetch_pred_taken = fp; fetch_alt_pc = alt;
        ex_res_valid = rv; ex_actual_taken = act;
        @(posedge clk);
        #1;
        fetch_br_valid = 1'b0; ex_res_valid = 1'b0; cfg_mode_wr = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_occ"}, 32'(occupancy), 0);
        check({tag, "_rdy"}, 32'(fetch_ready), 1);
        check({tag, "_pres"}, 32'(pred_result), 0);
        check({tag, "_flush"}, 32'(flush), 0);
        check({tag, "_redir"}, redirect_pc, 0);
        check({tag, "_forcer"}, 32'(forcer), 1);
        check({tag, "_hit"}, 32'(hit_count), 0);
        check({tag, "_miss"}, 32'(miss_count), 0);
        check({tag, "_err"}, 32'(err_underflow), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b1;

        cyc(1, 1, 32'h100, 0, 0);
        cyc(1, 0, 32'h200, 0, 0);
        cyc(1, 1, 32'h300, 0, 0);
        check("occ3", 32'(occupancy), 3);
        check("rdy3", 32'(fetch_ready), 1);
        cyc(0, 0, 0, 1, 1);
        check("pres_a", 32'(pred_result), 3'b111);
        check("flush_a", 32'(flush), 0);
        cyc(0, 0, 0, 1, 0);
        check("pres_b", 32'(pred_result), 3'b100);
        check("flush_b", 32'(flush), 0);
        cyc(0, 0, 0, 1, 1);
        check("pres_c", 32'(pred_result), 3'b111);
        check("flush_c", 32'(flush), 0);
        check("hit3", 32'(hit_count), 3);
        cyc(0, 0, 0, 0, 0);
        check("pres_idle", 32'(pred_result), 0);
        check("occ0", 32'(occupancy), 0);

        cyc(1, 1, 32'h40, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check("miss_pres", 32'(pred_result), 3'b110);
        check("miss_flush", 32'(flush), 1);
        check("miss_redir", redirect_pc, 32'h40);
        check("miss_cnt1", 32'(miss_count), 1);
        check("miss_occ", 32'(occupancy), 0);
        cyc(0, 0, 0, 0, 0);
        check("flush_pulse", 32'(flush), 0);
        check("pres_pulse", 32'(pred_result), 0);

        for (int i = 0; i < 4; i++) begin
            cyc(1, i[0], 32'h1000 + i, 0, 0);
            mpred.push_back(i[0]);
            malt.push_back(32'h1000 + i);
        end
        check("full_occ", 32'(occupancy), 4);
        check("full_rdy", 32'(fetch_ready), 0);
        cyc(1, 1, 32'h2000, 0, 0);
        check("drop_occ", 32'(occupancy), 4);
        a = mpred.pop_front();
        void'(malt.pop_front());
        cyc(0, 0, 0, 1, a);
        check("pop_occ", 32'(occupancy), 3);
        for (int i = 0; i < 10; i++) begin
            a = mpred.pop_front();
            void'(malt.pop_front());
            mpred.push_back(i % 3 == 0);
            malt.push_back(32'h3000 + i);
            cyc(1, i % 3 == 0, 32'h3000 + i, 1, a);
            check("wrap_pres", 32'(pred_result), {1'b1, a, a});
            check("wrap_occ", 32'(occupancy), 3);
        end
        check("hit14", 32'(hit_count), 14);
        cyc(0, 0, 0, 1, !mpred[0]);
        check("wrap_miss_pres", 32'(pred_result), {1'b1, mpred[0], !mpred[0]});
        check("wrap_miss_redir", redirect_pc, malt[0]);
        check("wrap_miss_occ", 32'(occupancy), 0);

        cyc(1, 1, 32'h500, 0, 0);
        cyc(1, 0, 32'h600, 0, 0);
        cyc(1, 1, 32'h700, 1, 0);
        check("pm_flush", 32'(flush), 1);
        check("pm_redir", redirect_pc, 32'h500);
        check("pm_occ", 32'(occupancy), 0);
        check("miss_cnt3", 32'(miss_count), 3);
        cyc(0, 0, 0, 0, 0);
        check("pm_absent", 32'(occupancy), 0);

        cyc(1, 1, 32'h10, 0, 0);
        cyc(1, 1, 32'h20, 0, 0);
        cfg_mode_wr = 1'b1; cfg_mode = 2'b11;
        cyc(0, 0, 0, 0, 0);
        check("mode_hold0", 32'(forcer), 1);
        cyc(0, 0, 0, 1, 1);
        check("mode_hold1", 32'(forcer), 1);
        cyc(0, 0, 0, 1, 1);
        check("mode_hold2", 32'(forcer), 1);
        cyc(0, 0, 0, 0, 0);
        check("mode_apply", 32'(forcer), 3);
        check("hit_sat", 32'(hit_count), 15);
        cyc(0, 0, 0, 1, 1);
        check("uflow_err", 32'(err_underflow), 1);
        check("uflow_pres", 32'(pred_result), 0);
        check("uflow_flush", 32'(flush), 0);
        cyc(0, 0, 0, 0, 0);
        check("uflow_sticky", 32'(err_underflow), 1);

        cyc(1, 1, 32'h80, 0, 0);
        cyc(1, 1, 32'h90, 0, 0);
        cyc(1, 1, 32'hA0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        check("pre_rst_occ", 32'(occupancy), 2);
        check("pre_rst_pres", 32'(pred_result), 3'b111);
        #2 rst = 1'b0;
        #1;
        check_reset("async");
        @(posedge clk);
        #1 rst = 1'b1;

        cyc(1, 1, 32'hC0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            cyc(1, 1, 32'hC0, 1, 1);
            if (i == 14) check("sat_15", 32'(hit_count), 15);
        end
        check("sat_17", 32'(hit_count), 15);
        check("sat_occ", 32'(occupancy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Controller that sequences the branch predictor in the 4-stage core. It records every predicted branch leaving fetch in an in-order queue and matches each one against the actual outcome from execute. It then drives the predictor's training `result` bus and raises the pipeline flush/redirect on a misprediction. It also owns the predictor's `forcer` mode register, applying mode changes only when no prediction is in flight.

## Interface
Parameters:
- DEPTH, 4, queue entries (power of 2, ≥2)
- PCW, 32, PC width
- CNTW, 16, width of hit/miss statistics counters

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- fetch_br_valid  in  1  fetch issued a branch with a prediction this cycle
- fetch_pred_taken  in  1  prediction used by fetch (predictor `jump`)
- fetch_alt_pc  in  PCW  PC of the path not chosen by the prediction
- fetch_ready  out  1  queue can accept a push (not full)
- ex_res_valid  in  1  execute resolved the oldest outstanding branch
- ex_actual_taken  in  1  actual branch outcome
- pred_result  out  3  to predictor `result`: {valid, predicted, actual}
- flush  out  1  squash younger instructions (one-cycle pulse)
- redirect_pc  out  PCW  fetch target while flush=1
- cfg_mode_wr  in  1  request new predictor mode
- cfg_mode  in  2  00 force not-taken, 11 force taken, 01/10 dynamic
- forcer  out  2  to predictor `forcer`
- occupancy  out  log2(DEPTH)+1  entries in flight
- hit_count  out  CNTW  correct predictions, saturating
- miss_count  out  CNTW  mispredictions, saturating
- err_underflow  out  1  sticky: resolve seen with empty queue

## Operation
- Queue: circular buffer of {pred_taken, alt_pc}; rd/wr pointers log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ and low bits equal; empty = pointers equal.
- Push: fetch_br_valid && fetch_ready writes the entry at wr_ptr. A push while full is dropped; fetch_ready=0 is fetch's responsibility to honour.
- Resolve: ex_res_valid with a non-empty queue pops the head and compares it with ex_actual_taken.
  - Hit (pred == actual): pred_result = {1, pred, actual}; hit_count +1.
  - Miss: pred_result = {1, pred, actual}; flush=1; redirect_pc = head alt_pc; miss_count +1; queue emptied (all younger entries invalid).
- Resolve on an empty queue: no pop, no pred_result, no flush; err_underflow set until reset.
- Simultaneous push and resolve:
  - Hit: both occur; occupancy unchanged.
  - Miss: the same-cycle push is discarded (it is younger).
- A push into a full queue in the same cycle as a pop is accepted only if fetch_ready was 1 (full is evaluated before the pop).
- Mode register:
  - cfg_mode_wr latches cfg_mode into pending.
  - Pending is applied to forcer on the first edge where the queue is empty and no push or resolve occurs.
  - A later write overwrites pending.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset (async assert, sync release):
  - Queue empty, occupancy=0, fetch_ready=1.
  - pred_result=000, flush=0, redirect_pc=0.
  - forcer=01, no pending mode.
  - Counters 0, err_underflow=0.
- pred_result, flush and redirect_pc are registered, valid the cycle after ex_res_valid, and held for exactly one cycle (pred_result returns to 000).
- The queue write is visible to occupancy/fetch_ready the cycle after the push.
- Mode apply: forcer changes on the edge after the idle conditions hold; minimum one cycle after cfg_mode_wr.
- Reset asserted mid-operation discards all entries and any in-progress flush pulse immediately.

## Test plan
- Reset, then 3 pushes (pred 1,0,1; alt_pc 0x100,0x200,0x300) -> occupancy=3, fetch_ready=1; resolve each matching -> pred_result 111, 100, 111 on successive cycles, hit_count=3, flush never high.
- Push pred=1 alt_pc=0x40, resolve actual=0 -> next cycle pred_result=110, flush=1, redirect_pc=0x40, miss_count=1, occupancy=0.
- Fill DEPTH=4 -> fetch_ready=0; push a 5th -> dropped, occupancy stays 4. Same-cycle push and hit-resolve when occupancy=3 -> occupancy stays 3; wr pointer wraps correctly over 10 cycles of this.
- Occupancy=2, same-cycle push and miss-resolve of the head -> flush=1, occupancy=0, the pushed entry is absent.
- cfg_mode_wr cfg_mode=11 with 2 entries in flight -> forcer stays 01 until both resolve, then becomes 11 on the next idle edge; ex_res_valid on empty queue -> err_underflow=1 and stays 1.
- Preload hit_count to all-ones via 2^CNTW hits (CNTW=4 build) -> the 17th hit leaves it at 15. Assert rst mid-queue -> all outputs at reset values asynchronously.
